irrigacao_escalonador: RTL



---
 rtl/irrigacao_pkg.sv | 17 +
 rtl/temporizador.sv | 18 +
 rtl/irrigacao_escalonador.sv | 85 ++++++++
 3 files changed

// File: rtl/irrigacao_pkg.sv
// irrigacao_pkg: shared state encoding, display select constants and default timings
package irrigacao_pkg;
  typedef enum logic [2:0] {
    S_OCIOSO   = 3'd0,
    S_GOTEJA   = 3'd1,
    S_ASPERSAO = 3'd2,
    S_PAUSA    = 3'd3,
    S_FALHA    = 3'd4
  } estado_t;
  localparam logic TANQUE = 1'b1;
  localparam logic IRRIGA = 1'b0;
  localparam int DEF_MIN_ON = 16;
  localparam int DEF_MAX_ON = 1024;
  localparam int DEF_PAUSA = 8;
  localparam int DEF_DISP_PERIOD = 50000000;
  localparam int DEF_CNT_W = 32;
endpackage

// File: rtl/temporizador.sv
// temporizador: loadable saturating up-counter with terminal-count flag
module temporizador #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (rst || load_i) ? '0 : (en_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  assign cnt_o = cnt_q;
  assign tc_o = cnt_q == lim_i;
endmodule

// File: rtl/irrigacao_escalonador.sv
// irrigacao_escalonador: arbitrates drip/sprinkler runs, drives fill valve and display select
module irrigacao_escalonador
  import irrigacao_pkg::*;
#(
  parameter int MIN_ON = DEF_MIN_ON,
  parameter int MAX_ON = DEF_MAX_ON,
  parameter int PAUSA = DEF_PAUSA,
  parameter int DISP_PERIOD = DEF_DISP_PERIOD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_got,
  input  logic       req_asp,
  input  logic       erro,
  input  logic       alarme,
  input  logic       nivel_h,
  input  logic       nivel_m,
  output logic       got_en,
  output logic       asp_en,
  output logic       valvula_en,
  output logic       disp_sel,
  output logic       falha,
  output logic [2:0] estado
);
  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_ON - 1);
  localparam logic [CNT_W-1:0] PAU_L = CNT_W'(PAUSA - 1);
  localparam logic [CNT_W-1:0] DSP_L = CNT_W'(DISP_PERIOD - 1);
  estado_t state_q, state_d;
  logic ultimo_q, ultimo_d, tog_q, tog_d;
  logic run_load, run_tc, disp_tc;
  logic [CNT_W-1:0] cnt, disp_cnt_unused;
  assign run_load = (state_d != state_q) || (state_q inside {S_OCIOSO, S_FALHA});
  temporizador #(.W(CNT_W)) u_run (
    .clk(clk), .rst(rst), .load_i(run_load), .en_i(1'b1),
    .lim_i(state_q == S_PAUSA ? PAU_L : MAX_L), .cnt_o(cnt), .tc_o(run_tc)
  );
  temporizador #(.W(CNT_W)) u_disp (
    .clk(clk), .rst(rst), .load_i(disp_tc), .en_i(1'b1),
    .lim_i(DSP_L), .cnt_o(disp_cnt_unused), .tc_o(disp_tc)
  );
  assign tog_d = disp_tc ? ~tog_q : tog_q;
  always_comb begin
    state_d = state_q;
    ultimo_d = ultimo_q;
    if (erro || alarme) state_d = S_FALHA;
    else case (state_q)
      S_OCIOSO:
        if (req_got && (!req_asp || ultimo_q)) begin
          state_d = S_GOTEJA;
          ultimo_d = 1'b0;
        end else if (req_asp) begin
          state_d = S_ASPERSAO;
          ultimo_d = 1'b1;
        end
      S_GOTEJA:   state_d = ((cnt >= MIN_L && !req_got) || run_tc) ? S_PAUSA : S_GOTEJA;
      S_ASPERSAO: state_d = ((cnt >= MIN_L && !req_asp) || run_tc) ? S_PAUSA : S_ASPERSAO;
      S_PAUSA:    state_d = run_tc ? S_OCIOSO : S_PAUSA;
      default:    state_d = (state_q == S_FALHA) ? S_PAUSA : S_FALHA;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OCIOSO;
      ultimo_q <= 1'b0;
      tog_q <= IRRIGA;
      got_en <= 1'b0;
      asp_en <= 1'b0;
      falha <= 1'b0;
      disp_sel <= IRRIGA;
      valvula_en <= 1'b0;
    end else begin
      state_q <= state_d;
      ultimo_q <= ultimo_d;
      tog_q <= tog_d;
      got_en <= state_d == S_GOTEJA;
      asp_en <= state_d == S_ASPERSAO;
      falha <= state_d == S_FALHA;
      disp_sel <= (state_d == S_FALHA) ? TANQUE : tog_d;
      valvula_en <= (nivel_h || erro) ? 1'b0 : (!nivel_m ? 1'b1 : valvula_en);
    end
  end
  assign estado = state_q;
endmodule
